// File: rtl/cp0_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared CP0 register indices, exception codes and handler PC.
// Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] CP0_HANDLER_PC = 32'h0000_4180;

endpackage
`default_nettype wire

// File: rtl/cp0_unit_req_gen.sv
`default_nettype none
// ============================================================================
// Module      : cp0_req_gen
// Description : Combinational exception/interrupt request and ExcCode select.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_req_gen
    import cp0_pkg::*;
(
    input  logic [5:0] i_sr_im,
    input  logic       i_sr_ie,
    input  logic       i_sr_exl,
    input  logic [5:0] i_hwint,
    input  logic [4:0] i_exccode,
    output logic       o_req,
    output logic [4:0] o_code
);

    logic w_int_req;
    logic w_exc_req;

    assign w_int_req = (|(i_hwint & i_sr_im)) & i_sr_ie & ~i_sr_exl;
    assign w_exc_req = (i_exccode != 5'd0) & ~i_sr_exl;
    assign o_req     = w_int_req | w_exc_req;
    // Interrupt outranks a synchronous exception
    assign o_code    = w_int_req ? EXC_INT : i_exccode;

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// Module      : cp0_unit
// Description : Coprocessor-0 (SR/Cause/EPC/PRId) and M-stage exception request.
//               Define CP0_PRID_EN to make index 15 return PRID_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h2024_0007,
    parameter logic [31:0] HANDLER_PC = CP0_HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] din,
    input  logic        cp0_we,
    input  logic [31:0] M_pc,
    input  logic        M_bd,
    input  logic [4:0]  M_Exccode,
    input  logic        M_eret,
    input  logic [5:0]  HWInt,
    output logic [31:0] dout,
    output logic [31:0] EPC_out,
    output logic        req,
    output logic        exl
);

    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_req;
    logic [4:0]  w_code;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused_params;

    cp0_req_gen u_req_gen (
        .i_sr_im   (r_sr_im),
        .i_sr_ie   (r_sr_ie),
        .i_sr_exl  (r_sr_exl),
        .i_hwint   (HWInt),
        .i_exccode (M_Exccode),
        .o_req     (w_req),
        .o_code    (w_code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= 6'd0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 6'd0;
            r_cause_exc <= 5'd0;
            r_epc       <= 32'd0;
        end else begin
            r_cause_ip <= HWInt;
            if (w_req) begin
                // The M instruction is flushed, so its mtc0/eret never commit
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= M_bd;
                r_cause_exc <= w_code;
                r_epc       <= M_bd ? (M_pc - 32'd4) : M_pc;
            end else begin
                if (M_eret) begin
                    r_sr_exl <= 1'b0;
                end
                if (cp0_we) begin
                    if (A2 == CP0_SR) begin
                        r_sr_im  <= din[15:10];
                        r_sr_exl <= din[1];
                        r_sr_ie  <= din[0];
                    end else if (A2 == CP0_EPC) begin
                        r_epc <= din;
                    end
                end
            end
        end
    end

    always_comb begin
        w_sr        = 32'd0;
        w_sr[15:10] = r_sr_im;
        w_sr[1]     = r_sr_exl;
        w_sr[0]     = r_sr_ie;
    end

    always_comb begin
        w_cause        = 32'd0;
        w_cause[31]    = r_cause_bd;
        w_cause[15:10] = r_cause_ip;
        w_cause[6:2]   = r_cause_exc;
    end

    always_comb begin
        dout = 32'd0;
        case (A1)
            CP0_SR:    dout = w_sr;
            CP0_CAUSE: dout = w_cause;
            CP0_EPC:   dout = r_epc;
`ifdef CP0_PRID_EN
            CP0_PRID:  dout = PRID_VAL;
`endif
            default:   dout = 32'd0;
        endcase
    end

    // Bypass lets an eret right behind an mtc0 EPC return to the new address
    assign EPC_out = (cp0_we && (A2 == CP0_EPC)) ? din : r_epc;
    assign req     = w_req;
    assign exl     = r_sr_exl;

    assign w_unused_params = ^{PRID_VAL, HANDLER_PC};

endmodule
`default_nettype wire
